// File: rtl/argon_mem_unit.sv
// argon_mem_unit: word-organised RAM slave with byte/half/word access, load extension, fault checks and wait states.
module argon_mem_unit #(
    parameter int    DEPTH_WORDS = 1024,
    parameter int    WAIT_STATES = 0,
    parameter string INIT_FILE   = "mem_init.hex"
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req,
    input  logic [31:0] i_mem_addr,
    input  logic [31:0] i_mem_wr_data,
    input  logic [2:0]  i_mem_rd_mask,
    input  logic [1:0]  i_mem_wr_mask,
    output logic        o_ready,
    output logic        o_done,
    output logic        o_fault,
    output logic [31:0] o_mem_rd_data
);
    localparam int AW = DEPTH_WORDS > 1 ? $clog2(DEPTH_WORDS) : 1;
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;
    state_t         state_q;
    logic [3:0]     cnt_q;
    logic [AW+1:0]  addr_q;
    logic [31:0]    wdata_q;
    logic [2:0]     rd_q;
    logic [1:0]     wr_q;
    logic           fault_q;
    logic [31:0]    rd_data_q;
    logic [31:0]    mem [DEPTH_WORDS];
    logic        is_half, is_word, fault_d;
    logic [31:0] word_d, wrep_d, rd_ext_d;
    logic [7:0]  byte_d;
    logic [15:0] half_d;
    logic [3:0]  be_d;
    logic [AW-1:0] idx_d;
    always_comb begin
        is_half  = i_mem_rd_mask == 3'd3 || i_mem_rd_mask == 3'd4 || i_mem_wr_mask == 2'd2;
        is_word  = i_mem_rd_mask == 3'd5 || i_mem_wr_mask == 2'd3;
        fault_d  = (|i_mem_rd_mask && |i_mem_wr_mask) || i_mem_rd_mask > 3'd5 ||
                   (is_half && i_mem_addr[0]) || (is_word && |i_mem_addr[1:0]) ||
                   {2'b00, i_mem_addr[31:2]} >= 32'(DEPTH_WORDS);
        idx_d    = addr_q[AW+1:2];
        word_d   = mem[idx_d];
        byte_d   = word_d[{addr_q[1:0], 3'b000} +: 8];
        half_d   = addr_q[1] ? word_d[31:16] : word_d[15:0];
        rd_ext_d = rd_q == 3'd1 ? {24'd0, byte_d} :
                   rd_q == 3'd2 ? {{24{byte_d[7]}}, byte_d} :
                   rd_q == 3'd3 ? {16'd0, half_d} :
                   rd_q == 3'd4 ? {{16{half_d[15]}}, half_d} :
                   rd_q == 3'd5 ? word_d : 32'd0;
        be_d     = wr_q == 2'd1 ? 4'b0001 << addr_q[1:0] :
                   wr_q == 2'd2 ? (addr_q[1] ? 4'b1100 : 4'b0011) :
                   wr_q == 2'd3 ? 4'b1111 : 4'b0000;
        wrep_d   = wr_q == 2'd1 ? {4{wdata_q[7:0]}} :
                   wr_q == 2'd2 ? {2{wdata_q[15:0]}} : wdata_q;
    end
    always_ff @(posedge i_clk) begin
        if (state_q == S_ACCESS)
            for (int i = 0; i < 4; i++)
                if (be_d[i]) mem[idx_d][8*i +: 8] <= wrep_d[8*i +: 8];
    end
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            addr_q    <= '0;
            wdata_q   <= 32'd0;
            rd_q      <= 3'd0;
            wr_q      <= 2'd0;
            fault_q   <= 1'b0;
            rd_data_q <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: if (i_req) begin
                    addr_q  <= i_mem_addr[AW+1:0];
                    wdata_q <= i_mem_wr_data;
                    rd_q    <= i_mem_rd_mask;
                    wr_q    <= i_mem_wr_mask;
                    fault_q <= fault_d;
                    cnt_q   <= 4'(WAIT_STATES - 1);
                    if (fault_d) rd_data_q <= 32'd0;
                    state_q <= fault_d ? S_DONE : WAIT_STATES > 0 ? S_WAIT : S_ACCESS;
                end
                S_WAIT: begin
                    cnt_q   <= cnt_q - 4'd1;
                    state_q <= cnt_q == 4'd0 ? S_ACCESS : S_WAIT;
                end
                S_ACCESS: begin
                    if (wr_q == 2'd0) rd_data_q <= rd_ext_d;
                    state_q <= S_DONE;
                end
                default: begin
                    if (fault_q) rd_data_q <= 32'd0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end
    assign o_ready       = state_q == S_IDLE;
    assign o_done        = state_q == S_DONE;
    assign o_fault       = state_q == S_DONE && fault_q;
    assign o_mem_rd_data = rd_data_q;
endmodule

// File: tb/tb_argon_mem_unit.sv
// tb_argon_mem_unit: scoreboard bench for argon_mem_unit with zero and three wait states.
module tb_argon_mem_unit;
    logic        clk = 1'b0, rst = 1'b0, req0 = 1'b0, req3 = 1'b0;
    logic [31:0] addr = 32'd0, wd = 32'd0;
    logic [2:0]  rm = 3'd0;
    logic [1:0]  wm = 2'd0;
    logic        rdy0, done0, flt0, rdy3, done3, flt3;
    logic [31:0] rd0, rd3;
    int checks = 0, failures = 0;
    typedef struct {logic [31:0] d; logic chk; logic f; int lat; string nm;} exp_t;
    exp_t sb[$];
    always #5 clk = ~clk;
    argon_mem_unit #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut0 (
        .i_clk(clk), .i_reset(rst), .i_req(req0), .i_mem_addr(addr), .i_mem_wr_data(wd),
        .i_mem_rd_mask(rm), .i_mem_wr_mask(wm), .o_ready(rdy0), .o_done(done0),
        .o_fault(flt0), .o_mem_rd_data(rd0));
    argon_mem_unit #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) dut3 (
        .i_clk(clk), .i_reset(rst), .i_req(req3), .i_mem_addr(addr), .i_mem_wr_data(wd),
        .i_mem_rd_mask(rm), .i_mem_wr_mask(wm), .o_ready(rdy3), .o_done(done3),
        .o_fault(flt3), .o_mem_rd_data(rd3));
    function automatic logic dn(int s); return s == 3 ? done3 : done0; endfunction
    task automatic do_req(input int s, input logic [31:0] a, input logic [31:0] w,
                          input logic [2:0] r, input logic [1:0] m, input logic [31:0] ed,
                          input logic chk, input logic ef, input string nm);
        exp_t e;
        int got = 0;
        @(negedge clk);
        addr = a; wd = w; rm = r; wm = m;
        if (s == 3) req3 = 1'b1; else req0 = 1'b1;
        sb.push_back('{ed, chk, ef, ef ? 1 : (s == 3 ? 5 : 2), nm});
        @(posedge clk);
        @(negedge clk);
        req0 = 1'b0; req3 = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (dn(s)) begin got = k; break; end
            @(negedge clk);
        end
        e = sb.pop_front();
        checks++;
        if (got !== e.lat) begin failures++; $display("FAIL %s latency got=%0d exp=%0d", e.nm, got, e.lat); end
        checks++;
        if ((s == 3 ? flt3 : flt0) !== e.f) begin failures++; $display("FAIL %s fault got=%b exp=%b", e.nm, s == 3 ? flt3 : flt0, e.f); end
        if (e.chk) begin
            checks++;
            if ((s == 3 ? rd3 : rd0) !== e.d) begin failures++; $display("FAIL %s data got=%h exp=%h", e.nm, s == 3 ? rd3 : rd0, e.d); end
        end
    endtask
    task automatic test_reset;
        rst = 1'b1;
        #12;
        checks++;
        if ({rdy0, done0, flt0, rd0, rdy3, done3, flt3, rd3} !== {3'b100, 32'd0, 3'b100, 32'd0}) begin
            failures++; $display("FAIL reset_state got=%b%b%b %h %b%b%b %h exp=100 0 100 0", rdy0, done0, flt0, rd0, rdy3, done3, flt3, rd3);
        end
        @(negedge clk); rst = 1'b0;
    endtask
    task automatic test_word_ext;
        do_req(0, 32'h10, 32'hDEADBEEF, 3'd0, 2'd3, 32'd0, 1'b0, 1'b0, "st_word");
        do_req(0, 32'h10, 32'd0, 3'd5, 2'd0, 32'hDEADBEEF, 1'b1, 1'b0, "ld_word");
        do_req(0, 32'h13, 32'd0, 3'd2, 2'd0, 32'hFFFFFFDE, 1'b1, 1'b0, "ld_byte_s");
        do_req(0, 32'h13, 32'd0, 3'd1, 2'd0, 32'h000000DE, 1'b1, 1'b0, "ld_byte_u");
        do_req(0, 32'h12, 32'd0, 3'd4, 2'd0, 32'hFFFFDEAD, 1'b1, 1'b0, "ld_half_s");
        do_req(0, 32'h10, 32'd0, 3'd3, 2'd0, 32'h0000BEEF, 1'b1, 1'b0, "ld_half_u");
    endtask
    task automatic test_partial;
        do_req(0, 32'h11, 32'hAAAAAA55, 3'd0, 2'd1, 32'd0, 1'b0, 1'b0, "st_byte");
        do_req(0, 32'h10, 32'd0, 3'd5, 2'd0, 32'hDEAD55EF, 1'b1, 1'b0, "ld_after_byte");
        do_req(0, 32'h12, 32'hBBBB1234, 3'd0, 2'd2, 32'd0, 1'b0, 1'b0, "st_half");
        do_req(0, 32'h10, 32'd0, 3'd5, 2'd0, 32'h123455EF, 1'b1, 1'b0, "ld_after_half");
    endtask
    task automatic test_faults;
        do_req(0, 32'h20, 32'hA5A5A5A5, 3'd0, 2'd3, 32'd0, 1'b0, 1'b0, "st_word20");
        do_req(0, 32'h10, 32'd0, 3'd5, 2'd0, 32'h123455EF, 1'b1, 1'b0, "ld_prefault");
        do_req(0, 32'h13, 32'd0, 3'd3, 2'd0, 32'd0, 1'b1, 1'b1, "flt_half_mis");
        do_req(0, 32'h22, 32'h0BADF00D, 3'd0, 2'd3, 32'd0, 1'b1, 1'b1, "flt_word_st_mis");
        do_req(0, 32'h1000, 32'd0, 3'd5, 2'd0, 32'd0, 1'b1, 1'b1, "flt_range");
        do_req(0, 32'h10, 32'd0, 3'd7, 2'd0, 32'd0, 1'b1, 1'b1, "flt_rdmask7");
        do_req(0, 32'h10, 32'hFFFFFFFF, 3'd5, 2'd3, 32'd0, 1'b1, 1'b1, "flt_both");
        do_req(0, 32'h20, 32'd0, 3'd5, 2'd0, 32'hA5A5A5A5, 1'b1, 1'b0, "rb_20");
        do_req(0, 32'h10, 32'd0, 3'd5, 2'd0, 32'h123455EF, 1'b1, 1'b0, "rb_10");
    endtask
    task automatic test_wait_states;
        exp_t e;
        int extra = 0;
        do_req(3, 32'h40, 32'h11111111, 3'd0, 2'd3, 32'd0, 1'b0, 1'b0, "ws_store");
        do_req(3, 32'h40, 32'd0, 3'd5, 2'd0, 32'h11111111, 1'b1, 1'b0, "ws_load");
        do_req(3, 32'h41, 32'd0, 3'd5, 2'd0, 32'd0, 1'b1, 1'b1, "ws_fault");
        @(negedge clk);
        addr = 32'h40; rm = 3'd5; wm = 2'd0; req3 = 1'b1;
        sb.push_back('{32'h11111111, 1'b1, 1'b0, 5, "ws_held"});
        @(posedge clk);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checks++;
            if (rdy3 !== 1'b0 || done3 !== (k == 5)) begin
                failures++; $display("FAIL ws_held_c%0d ready=%b done=%b exp ready=0 done=%b", k, rdy3, done3, k == 5);
            end
        end
        e = sb.pop_front();
        checks++;
        if (rd3 !== e.d) begin failures++; $display("FAIL %s data got=%h exp=%h", e.nm, rd3, e.d); end
        @(negedge clk);
        checks++;
        if (rdy3 !== 1'b1) begin failures++; $display("FAIL ws_ready_back got=%b exp=1", rdy3); end
        req3 = 1'b0;
        for (int k = 0; k < 8; k++) begin @(negedge clk); if (done3) extra++; end
        checks++;
        if (extra !== 0) begin failures++; $display("FAIL ws_no_second got=%0d exp=0", extra); end
    endtask
    task automatic test_reset_abort;
        int extra = 0;
        @(negedge clk);
        addr = 32'h40; wd = 32'hCAFEF00D; rm = 3'd0; wm = 2'd3; req3 = 1'b1;
        @(posedge clk);
        @(negedge clk); req3 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (rdy3 !== 1'b1 || done3 !== 1'b0) begin failures++; $display("FAIL abort_ready got=%b%b exp=10", rdy3, done3); end
        @(negedge clk); rst = 1'b0;
        for (int k = 0; k < 10; k++) begin @(negedge clk); if (done3) extra++; end
        checks++;
        if (extra !== 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", extra); end
        do_req(3, 32'h40, 32'd0, 3'd5, 2'd0, 32'h11111111, 1'b1, 1'b0, "abort_rb");
        do_req(0, 32'h10, 32'd0, 3'd5, 2'd0, 32'h123455EF, 1'b1, 1'b0, "abort_rb_ws0");
    endtask
    initial begin
        test_reset;
        test_word_ext;
        test_partial;
        test_faults;
        test_wait_states;
        test_reset_abort;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/argon_mem_unit.md
Name: argon_mem_unit

Overview:
- Data/instruction memory slave that sits directly downstream of the Argon core's memory port and consumes its address, write data, read mask and write mask.
- Holds a word-organised synchronous RAM and performs byte, halfword and word accesses, little-endian.
- Sign- or zero-extends loads, merges partial stores by byte lane, and flags misaligned, out-of-range or illegal-mask requests.
- Adds a req/ready/done handshake and a programmable wait-state counter so the core's fetch and MEM stages can stall on it.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the array; valid byte addresses are 0 .. 4*DEPTH_WORDS-1.
- WAIT_STATES, 0, extra access cycles inserted before the array access; legal range 0..15.
- INIT_FILE, "mem_init.hex", hex image loaded when the optional feature is enabled.

Ports:
- i_clk  in  1  system clock (core's gated sys_clk).
- i_reset  in  1  asynchronous reset, active-high.
- i_req  in  1  request strobe; sampled only when o_ready=1.
- i_mem_addr  in  32  byte address.
- i_mem_wr_data  in  32  store data; byte uses [7:0], half uses [15:0].
- i_mem_rd_mask  in  3  read mask: 0 none, 1 byte unsigned, 2 byte signed, 3 half unsigned, 4 half signed, 5 word; 6 and 7 are illegal.
- i_mem_wr_mask  in  2  write mask: 0 none, 1 byte, 2 half, 3 word.
- o_ready  out  1  1 when idle and able to accept i_req.
- o_done  out  1  one-cycle completion pulse.
- o_fault  out  1  valid with o_done; 1 means the request was rejected.
- o_mem_rd_data  out  32  load result, valid from o_done until the next completion.

Behaviour:
- Clock and reset: one clock, i_clk. i_reset is asynchronous and active-high.
- Reset values: state IDLE, o_ready=1, o_done=0, o_fault=0, o_mem_rd_data=0, wait counter 0. The RAM array is not cleared.
- States: IDLE, WAIT, ACCESS, DONE. o_ready = (state==IDLE).
- IDLE: on i_req=1, latch address, write data and masks, then check for a fault.
  - Fault conditions: both masks nonzero; rd mask 6 or 7; half access with addr[0]=1; word access with addr[1:0]!=0; addr[31:2] >= DEPTH_WORDS.
  - On fault: go to DONE with the fault flag set. The RAM is untouched.
  - Otherwise: go to WAIT (counter loaded with WAIT_STATES-1) if WAIT_STATES>0, else go to ACCESS.
- WAIT: decrement the counter; at 0 go to ACCESS.
- ACCESS:
  - Write: update only the enabled byte lanes of mem[addr[31:2]]. Byte lane n = addr[1:0], bits [8n+7:8n]; half lane = addr[1].
  - Read: select the addressed lane, extend per the mask, register the result into o_mem_rd_data.
  - Both masks zero: no-op, o_mem_rd_data <= 0.
  - Always go to DONE.
- DONE: o_done=1 and o_fault = latched fault flag; on fault o_mem_rd_data <= 0. Always go to IDLE.
- Latency, with i_req sampled at the end of cycle c:
  - Normal access: o_done high in cycle c+2+WAIT_STATES.
  - Fault: o_done high in cycle c+1.
  - Back-to-back: the next request is accepted in the cycle after DONE.
- i_req while o_ready=0 is ignored and is not queued.
- Inputs are sampled only in IDLE, so changes to i_mem_* while busy have no effect.
- Reset mid-operation: return to IDLE immediately. A store that has not reached its ACCESS edge is dropped, and no o_done is produced for the aborted request.
- Address bits [31:2] beyond log2(DEPTH_WORDS) take part only in the range check.

Optional Feature:
- ARGON_MEM_PRELOAD_EN defined: the array is initialised at elaboration with $readmemh(INIT_FILE) so the core can boot from a program image. Reset still does not touch the array.
- Undefined: no initialisation; the array power-up contents are X in simulation, and software must store before it loads.

Test Plan:
- Word store/load: store 0xDEADBEEF at 0x10 (wr mask 3), then load word (rd mask 5) from 0x10 -> o_mem_rd_data=0xDEADBEEF, o_fault=0, o_done in cycle c+2 with WAIT_STATES=0.
- Extension on the above data:
  - byte signed 0x13 -> 0xFFFFFFDE
  - byte unsigned 0x13 -> 0x000000DE
  - half signed 0x12 -> 0xFFFFDEAD
  - half unsigned 0x10 -> 0x0000BEEF
- Partial store: store byte 0x55 at 0x11, then load word 0x10 -> 0xDEAD55EF; store half 0x1234 at 0x12, then load word -> 0x123455EF.
- Faults, each giving o_done in c+1, o_fault=1, o_mem_rd_data=0, and RAM unchanged on later readback:
  - half load at 0x13
  - word store at 0x22
  - word load at 0x1000 with DEPTH_WORDS=1024
  - rd mask 7
  - rd mask 5 together with wr mask 3
- Wait states (WAIT_STATES=3): word load -> o_done in c+5; o_ready low in cycles c+1..c+5; i_req held high during busy causes no second access until o_ready returns.
- Reset abort (WAIT_STATES=3): start a word store of 0xCAFEF00D at 0x40 over old value 0x11111111 and assert i_reset during WAIT -> o_done never pulses, o_ready=1 immediately, later load of 0x40 returns 0x11111111.
